// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - traffic light phase sequencer driving a countdown counter
// RED -> GREEN -> YELLOW -> RED with pedestrian-extended RED and maintenance flashing yellow.
module traffic_phase_ctrl #(
  parameter int RED_TIME     = 18,
  parameter int GREEN_TIME   = 15,
  parameter int YELLOW_TIME  = 3,
  parameter int RED_PED_TIME = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] counter_value,
  input  logic       ped_req,
  input  logic       maint,
  output logic [5:0] timer_value,
  output logic [1:0] phase,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic       walk,
  output logic       ped_pending
);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_FLASH  = 2'd3
  } phase_t;

  localparam logic [5:0] RED_T     = 6'(RED_TIME);
  localparam logic [5:0] GREEN_T   = 6'(GREEN_TIME);
  localparam logic [5:0] YELLOW_T  = 6'(YELLOW_TIME);
  localparam logic [5:0] RED_PED_T = 6'(RED_PED_TIME);

  phase_t     state_q, state_d;
  logic       holdoff_q, holdoff_d;
  logic [5:0] timer_d;
  logic       red_d, yellow_d, green_d, walk_d, ped_d;
  logic       adv;

  // holdoff hides the counter's stale value during the cycle it reloads
  assign adv   = !holdoff_q && (counter_value == 6'd0) && (state_q != PH_FLASH) && !maint;
  assign phase = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PH_RED;
      holdoff_q   <= 1'b1;
      timer_value <= RED_T;
      red         <= 1'b1;
      yellow      <= 1'b0;
      green       <= 1'b0;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdoff_q   <= holdoff_d;
      timer_value <= timer_d;
      red         <= red_d;
      yellow      <= yellow_d;
      green       <= green_d;
      walk        <= walk_d;
      ped_pending <= ped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    holdoff_d = 1'b0;
    timer_d   = timer_value;
    red_d     = red;
    yellow_d  = yellow;
    green_d   = green;
    walk_d    = walk;
    ped_d     = ped_pending;

    if (state_q != PH_FLASH && maint) begin
      state_d   = PH_FLASH;
      holdoff_d = 1'b1;
      timer_d   = 6'd0;
      red_d     = 1'b0;
      yellow_d  = 1'b1;
      green_d   = 1'b0;
      walk_d    = 1'b0;
      ped_d     = 1'b0;
    end else if (state_q == PH_FLASH) begin
      ped_d = 1'b0;
      if (maint) begin
        yellow_d = !yellow;
      end else begin
        state_d   = PH_RED;
        holdoff_d = 1'b1;
        timer_d   = RED_T;
        red_d     = 1'b1;
        yellow_d  = 1'b0;
        green_d   = 1'b0;
        walk_d    = 1'b0;
      end
    end else begin
      if (adv) begin
        holdoff_d = 1'b1;
        case (state_q)
          PH_RED: begin
            state_d = PH_GREEN;
            timer_d = GREEN_T;
            red_d   = 1'b0;
            green_d = 1'b1;
            walk_d  = 1'b0;
          end
          PH_GREEN: begin
            state_d  = PH_YELLOW;
            timer_d  = YELLOW_T;
            green_d  = 1'b0;
            yellow_d = 1'b1;
          end
          PH_YELLOW: begin
            state_d  = PH_RED;
            yellow_d = 1'b0;
            red_d    = 1'b1;
            if (ped_pending) begin
              timer_d = RED_PED_T;
              walk_d  = 1'b1;
              ped_d   = 1'b0;
            end else begin
              timer_d = RED_T;
              walk_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      // a fresh request wins over the clear so it is served on the next RED
      if (ped_req) ped_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - scoreboard bench for traffic_phase_ctrl
// Phase-schedule reference model plus a countdown counter model on the timer interface.
module tb_traffic_phase_ctrl;

  localparam int RT = 18, GT = 15, YT = 3, PT = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req = 1'b0;
  logic       maint = 1'b0;
  logic [5:0] counter_value;
  logic [5:0] timer_value;
  logic [1:0] phase;
  logic       red, yellow, green, walk, ped_pending;

  traffic_phase_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .counter_value(counter_value),
    .ped_req      (ped_req),
    .maint        (maint),
    .timer_value  (timer_value),
    .phase        (phase),
    .red          (red),
    .yellow       (yellow),
    .green        (green),
    .walk         (walk),
    .ped_pending  (ped_pending)
  );

  always #5 clk = ~clk;

  // counter model: loads during the first cycle of each phase, then counts down and holds at 0
  logic [5:0] cnt = 6'd0;
  logic [1:0] last_phase = 2'd0;
  logic       last_rst = 1'b0;
  logic       hold = 1'b0;
  assign counter_value = cnt;

  always @(negedge clk) begin
    hold       = last_rst || (phase != last_phase);
    last_phase = phase;
    last_rst   = reset;
  end

  always @(posedge clk) begin
    if (hold) cnt <= timer_value;
    else if (cnt != 6'd0) cnt <= cnt - 6'd1;
  end

  typedef struct packed {
    logic [5:0] tv;
    logic [1:0] ph;
    logic       r, y, g, w, p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  // reference model: phase, cycles spent in it, and its total length (duration + 2)
  int m_ph = 0, m_age = 0, m_len = RT + 2;
  bit m_pend = 0, m_walk = 0, m_fy = 0;

  task automatic model_step(input bit r, input bit p, input bit m);
    if (r) begin
      m_ph = 0; m_age = 0; m_len = RT + 2; m_pend = 0; m_walk = 0; m_fy = 0;
    end else if (m_ph != 3 && m) begin
      m_ph = 3; m_fy = 1; m_pend = 0; m_walk = 0;
    end else if (m_ph == 3) begin
      if (m) m_fy = !m_fy;
      else begin
        m_ph = 0; m_age = 0; m_len = RT + 2; m_walk = 0; m_fy = 0;
      end
    end else begin
      if (m_age == m_len - 1) begin
        m_age = 0;
        if (m_ph == 0) begin
          m_ph = 1; m_len = GT + 2; m_walk = 0;
        end else if (m_ph == 1) begin
          m_ph = 2; m_len = YT + 2;
        end else begin
          m_ph = 0;
          if (m_pend) begin
            m_walk = 1; m_len = PT + 2; m_pend = 0;
          end else begin
            m_walk = 0; m_len = RT + 2;
          end
        end
      end else begin
        m_age++;
      end
      if (p) m_pend = 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    case (m_ph)
      0:       e.tv = m_walk ? 6'(PT) : 6'(RT);
      1:       e.tv = 6'(GT);
      2:       e.tv = 6'(YT);
      default: e.tv = 6'd0;
    endcase
    e.ph = 2'(m_ph);
    e.r  = (m_ph == 0);
    e.g  = (m_ph == 1);
    e.y  = (m_ph == 2) || (m_ph == 3 && m_fy);
    e.w  = m_walk;
    e.p  = m_pend;
    return e;
  endfunction

  task automatic cycle(input bit r, input bit p, input bit m);
    reset   = r;
    ped_req = p;
    maint   = m;
    model_step(r, p, m);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  // advance until the model sits in phase ph, either at its last cycle or two cycles in
  task automatic go_to(input int ph, input bit at_end, input string tag);
    int n = 0;
    while (!(m_ph == ph && (at_end ? (m_age == m_len - 1) : (m_age == 2))) && n < 300) begin
      cycle(0, 0, 0);
      n++;
    end
    if (n >= 300) begin
      checks++;
      $display("FAIL timeout %s: waited %0d cycles, required phase %0d", tag, n, ph);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = '{timer_value, phase, red, yellow, green, walk, ped_pending};
      checks++;
      if (a === e) passed++;
      else $display("FAIL cycle %0d: got tv=%0d ph=%0d r=%0b y=%0b g=%0b w=%0b p=%0b, expected tv=%0d ph=%0d r=%0b y=%0b g=%0b w=%0b p=%0b",
                    cyc, a.tv, a.ph, a.r, a.y, a.g, a.w, a.p, e.tv, e.ph, e.r, e.y, e.g, e.w, e.p);
      cyc++;
    end
  end

  initial begin
    // reset and one undisturbed lap
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    repeat (46) cycle(0, 0, 0);

    // pedestrian pulse in GREEN, served on the following RED
    go_to(1, 0, "green for ped");
    cycle(0, 1, 0);
    go_to(0, 1, "end of walk red");
    repeat (30) cycle(0, 0, 0);

    // request on the exact YELLOW->RED cycle is deferred
    go_to(2, 1, "yellow end");
    cycle(0, 1, 0);
    repeat (70) cycle(0, 0, 0);

    // maintenance entered as GREEN expires
    go_to(1, 1, "green end");
    repeat (7) cycle(0, 0, 1);
    repeat (25) cycle(0, 0, 0);

    // reset mid-YELLOW with a pending request
    go_to(1, 0, "green for reset");
    cycle(0, 1, 0);
    go_to(2, 0, "mid yellow");
    cycle(1, 0, 0);
    repeat (25) cycle(0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, p, m;
      r = ($urandom_range(0, 599) == 0);
      p = ($urandom_range(0, 24) == 0);
      m = ($urandom_range(0, 299) == 0) ? !maint : maint;
      cycle(r, p, m);
    end
    cycle(0, 0, 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
